// File: rtl/systolic_pkg.sv
// Shared types and helpers for the multiprecision systolic PE: weight modes,
// weight buffer states and the product width rule.
package systolic_pkg;

  typedef enum logic [1:0] {
    W1 = 2'd0,
    W2 = 2'd1,
    W4 = 2'd2,
    W8 = 2'd3
  } wmode_t;

  typedef enum logic [1:0] {
    WS_EMPTY         = 2'd0,
    WS_SHADOW        = 2'd1,
    WS_ACTIVE        = 2'd2,
    WS_ACTIVE_SHADOW = 2'd3
  } wstate_t;

  localparam int WEIGHT_W = 8;

  function automatic int wbits(wmode_t m);
    case (m)
      W1:      return 1;
      W2:      return 2;
      W4:      return 4;
      default: return 8;
    endcase
  endfunction

  // Intermediate product width: activation plus a full 8-bit weight.
  function automatic int prod_w(int bit_size);
    return bit_size + WEIGHT_W;
  endfunction

endpackage

// File: rtl/pe_mult_mp.sv
// Combinational mode-selected multiply: activation times a 1/2/4/8-bit weight,
// rescaled so the weight acts as a signed fraction; result is BitSize+1 bits.
module pe_mult_mp
  import systolic_pkg::*;
#(
  parameter int BitSize = 8
) (
  input  logic signed [BitSize-1:0] in_data,
  input  logic        [7:0]         i_prod,
  input  wmode_t                    mode,
  output logic signed [BitSize:0]   out_data
);

  localparam int PROD_W = prod_w(BitSize);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] full;
  logic signed [PROD_W-1:0] shifted;

  always_comb begin
    a_ext = {{WEIGHT_W{in_data[BitSize-1]}}, in_data};
    w_ext = '0;
    // A 1-bit weight encodes +1 / -1, so it multiplies by +-1 with no rescale.
    case (mode)
      W1:      w_ext = i_prod[0] ? PROD_W'(1) : '1;
      W2:      w_ext = {{(PROD_W-2){i_prod[1]}}, i_prod[1:0]};
      W4:      w_ext = {{(PROD_W-4){i_prod[3]}}, i_prod[3:0]};
      default: w_ext = {{(PROD_W-8){i_prod[7]}}, i_prod};
    endcase
    full     = a_ext * w_ext;
    shifted  = full >>> (wbits(mode) - 1);
    out_data = (BitSize+1)'(shifted);
  end

endmodule

// File: rtl/systolic_pe_mp.sv
// Multiprecision systolic MAC PE with double-buffered weights. Activations go
// right, partial sums go down. Define SYSTOLIC_PE_SAT_EN for a saturating sum.
module systolic_pe_mp
  import systolic_pkg::*;
#(
  parameter int BitSize     = 8,
  parameter int M_W_BitSize = 8,
  parameter int CHAIN_ID    = 0
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   in_valid,
  input  logic [BitSize-1:0]     in_a,
  input  logic [BitSize-1:0]     in_partial_sum,
  input  logic [M_W_BitSize-1:0] in_b,
  input  logic                   in_b_valid,
  input  logic                   en_l_b,
  input  logic                   in_commit,
  input  logic [1:0]             in_mode,
  output logic [BitSize-1:0]     out_a,
  output logic [BitSize-1:0]     out_partial_sum,
  output logic                   out_valid,
  output logic [M_W_BitSize-1:0] out_b,
  output logic                   out_b_valid,
  output logic                   out_commit,
  output logic                   w_active
);

  if (M_W_BitSize < 8) begin : g_bad_width
    $error("systolic_pe_mp[%0d]: M_W_BitSize must be >= 8", CHAIN_ID);
  end

  // Handshake: in_valid qualifies in_a/in_partial_sum for exactly one cycle and
  // out_valid mirrors it one cycle later; there is no ready, the PE never stalls.
  wstate_t                w_state, w_state_nxt;
  logic [WEIGHT_W-1:0]    shadow_w, active_w;
  wmode_t                 active_mode;
  logic                   shadow_vld, active_vld, load;
  logic                   act_n, shd_n;
  logic signed [BitSize:0] prod, eff_prod, psum_ext, sum_full;
  logic [BitSize-1:0]     sum_out;

  assign load       = in_b_valid & en_l_b;
  assign shadow_vld = (w_state == WS_SHADOW) || (w_state == WS_ACTIVE_SHADOW);
  assign active_vld = (w_state == WS_ACTIVE) || (w_state == WS_ACTIVE_SHADOW);
  assign w_active   = active_vld;

  // A commit consumes the shadow; a same-cycle load refills it after the copy.
  always_comb begin
    w_state_nxt = w_state;
    act_n       = active_vld;
    shd_n       = shadow_vld | load;
    if (in_commit) begin
      act_n = shadow_vld;
      shd_n = load;
    end
    case ({act_n, shd_n})
      2'b00:   w_state_nxt = WS_EMPTY;
      2'b01:   w_state_nxt = WS_SHADOW;
      2'b10:   w_state_nxt = WS_ACTIVE;
      default: w_state_nxt = WS_ACTIVE_SHADOW;
    endcase
  end

  pe_mult_mp #(.BitSize(BitSize)) u_mult (
    .in_data  (in_a),
    .i_prod   (active_w),
    .mode     (active_mode),
    .out_data (prod)
  );

  always_comb begin
    eff_prod = active_vld ? prod : '0;
    psum_ext = {in_partial_sum[BitSize-1], in_partial_sum};
    sum_full = psum_ext + eff_prod;
`ifdef SYSTOLIC_PE_SAT_EN
    if (sum_full[BitSize] != sum_full[BitSize-1])
      sum_out = sum_full[BitSize] ? {1'b1, {(BitSize-1){1'b0}}}
                                  : {1'b0, {(BitSize-1){1'b1}}};
    else
      sum_out = sum_full[BitSize-1:0];
`else
    sum_out = BitSize'(sum_full);
`endif
  end

  always_ff @(posedge clk) begin
    if (res) begin
      w_state         <= WS_EMPTY;
      shadow_w        <= '0;
      active_w        <= '0;
      active_mode     <= W8;
      out_a           <= '0;
      out_partial_sum <= '0;
      out_valid       <= 1'b0;
      out_b           <= '0;
      out_b_valid     <= 1'b0;
      out_commit      <= 1'b0;
    end else begin
      w_state     <= w_state_nxt;
      out_b       <= in_b;
      out_b_valid <= in_b_valid;
      out_commit  <= in_commit;
      out_valid   <= in_valid;
      if (load) shadow_w <= in_b[WEIGHT_W-1:0];
      if (in_commit) begin
        active_w    <= shadow_w;
        active_mode <= wmode_t'(in_mode);
      end
      if (in_valid) begin
        out_a           <= in_a;
        out_partial_sum <= sum_out;
      end
    end
  end

  assert property (@(posedge clk) disable iff (res) in_commit |-> !$isunknown(in_mode))
    else $error("systolic_pe_mp[%0d]: commit with unknown mode", CHAIN_ID);

endmodule

// File: tb/tb_systolic_pe_mp.sv
// Self-checking bench for systolic_pe_mp: directed scenarios plus randomized
// traffic against a behavioural model, and a three-PE chain.
module tb_systolic_pe_mp;

  localparam int BW = 8;
  localparam int MW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          res, in_valid, in_b_valid, en_l_b, in_commit;
  logic [BW-1:0] in_a, in_psum;
  logic [MW-1:0] in_b;
  logic [1:0]    in_mode;

  logic [BW-1:0] out_a0, psum0, out_a1, psum1, out_a2, psum2;
  logic [MW-1:0] b0, b1, b2;
  logic          valid0, bv0, commit0, wact0;
  logic          valid1, bv1, commit1, wact1;
  logic          valid2, bv2, commit2, wact2;

  systolic_pe_mp #(.BitSize(BW), .M_W_BitSize(MW), .CHAIN_ID(0)) dut0 (
    .clk(clk), .res(res), .in_valid(in_valid), .in_a(in_a), .in_partial_sum(in_psum),
    .in_b(in_b), .in_b_valid(in_b_valid), .en_l_b(en_l_b), .in_commit(in_commit),
    .in_mode(in_mode), .out_a(out_a0), .out_partial_sum(psum0), .out_valid(valid0),
    .out_b(b0), .out_b_valid(bv0), .out_commit(commit0), .w_active(wact0));

  systolic_pe_mp #(.BitSize(BW), .M_W_BitSize(MW), .CHAIN_ID(1)) dut1 (
    .clk(clk), .res(res), .in_valid(valid0), .in_a(out_a0), .in_partial_sum(psum0),
    .in_b(b0), .in_b_valid(bv0), .en_l_b(en_l_b), .in_commit(commit0),
    .in_mode(in_mode), .out_a(out_a1), .out_partial_sum(psum1), .out_valid(valid1),
    .out_b(b1), .out_b_valid(bv1), .out_commit(commit1), .w_active(wact1));

  systolic_pe_mp #(.BitSize(BW), .M_W_BitSize(MW), .CHAIN_ID(2)) dut2 (
    .clk(clk), .res(res), .in_valid(valid1), .in_a(out_a1), .in_partial_sum(psum1),
    .in_b(b1), .in_b_valid(bv1), .en_l_b(en_l_b), .in_commit(commit1),
    .in_mode(in_mode), .out_a(out_a2), .out_partial_sum(psum2), .out_valid(valid2),
    .out_b(b2), .out_b_valid(bv2), .out_commit(commit2), .w_active(wact2));

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model (PE 0 only) ----------------
  logic [7:0]    m_shadow, m_active;
  bit            m_svld, m_avld;
  int            m_mode;
  logic [BW-1:0] exp_q[$];

  function automatic int sext(int v, int bits);
    int r;
    r = v & ((1 << bits) - 1);
    if (r >= (1 << (bits - 1))) r = r - (1 << bits);
    return r;
  endfunction

  function automatic int model_prod(int a, logic [7:0] w, int mode);
    int bits, wv;
    bits = 1 << mode;
    if (bits == 1) return w[0] ? a : -a;
    wv = sext(int'(w), bits);
    return sext((a * wv) >>> (bits - 1), BW + 1);
  endfunction

  function automatic logic [BW-1:0] model_mac(logic [BW-1:0] a, logic [BW-1:0] psum);
    int p, s;
    p = m_avld ? model_prod(sext(int'(a), BW), m_active, m_mode) : 0;
    s = sext(sext(int'(psum), BW) + p, BW + 1);
`ifdef SYSTOLIC_PE_SAT_EN
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
`endif
    return BW'(s);
  endfunction

  task automatic model_reset();
    m_shadow = '0; m_active = '0; m_svld = 0; m_avld = 0; m_mode = 3;
  endtask

  task automatic model_edge();
    bit ld;
    ld = in_b_valid & en_l_b;
    if (in_commit) begin
      m_active = m_shadow; m_mode = int'(in_mode); m_avld = m_svld; m_svld = ld;
    end else if (ld) m_svld = 1;
    if (ld) m_shadow = in_b[7:0];
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cycle();
    model_edge();
    tick();
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_a = '0; in_psum = '0; in_b = '0; in_b_valid = 0;
    en_l_b = 1; in_commit = 0; in_mode = 2'd3;
  endtask

  task automatic do_reset();
    idle_inputs();
    res = 1; tick(); tick(); res = 0;
    model_reset();
  endtask

  task automatic load_w(input logic [7:0] w);
    in_b = w; in_b_valid = 1; en_l_b = 1; cycle(); in_b_valid = 0;
  endtask

  task automatic commit_w(input logic [1:0] mode);
    in_commit = 1; in_mode = mode; cycle(); in_commit = 0;
  endtask

  task automatic mac(input logic [BW-1:0] a, input logic [BW-1:0] psum);
    in_valid = 1; in_a = a; in_psum = psum; cycle(); in_valid = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    res = 1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom_range(0, 1)); in_a = BW'($urandom_range(0, 255));
      in_psum = BW'($urandom_range(0, 255)); in_b = MW'($urandom_range(0, 255));
      in_b_valid = 1; en_l_b = 1; in_commit = 1; in_mode = 2'($urandom_range(0, 3));
      tick();
    end
    n_tests++; if (out_a0 !== '0) begin n_fail++; $display("FAIL reset_out_a got %0h want 0", out_a0); end
    n_tests++; if (psum0 !== '0) begin n_fail++; $display("FAIL reset_psum got %0h want 0", psum0); end
    n_tests++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid0); end
    n_tests++; if (b0 !== '0) begin n_fail++; $display("FAIL reset_out_b got %0h want 0", b0); end
    n_tests++; if (bv0 !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid got %0b want 0", bv0); end
    n_tests++; if (commit0 !== 1'b0) begin n_fail++; $display("FAIL reset_commit got %0b want 0", commit0); end
    n_tests++; if ({wact0, wact1, wact2} !== 3'b000) begin n_fail++; $display("FAIL reset_w_active got %0b want 000", {wact0, wact1, wact2}); end
    res = 0; idle_inputs(); model_reset();
  endtask

  task automatic test_mode8();
    do_reset();
    load_w(8'h40);
    commit_w(2'd3);
    n_tests++; if (wact0 !== 1'b1) begin n_fail++; $display("FAIL m8_w_active got %0b want 1", wact0); end
    mac(8'd20, 8'd3);
    n_tests++; if (psum0 !== 8'd13) begin n_fail++; $display("FAIL m8_psum got %0d want 13", psum0); end
    n_tests++; if (out_a0 !== 8'd20) begin n_fail++; $display("FAIL m8_out_a got %0d want 20", out_a0); end
    n_tests++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL m8_valid got %0b want 1", valid0); end
    in_a = 8'd99; in_psum = 8'd77; cycle();
    n_tests++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL stall_valid got %0b want 0", valid0); end
    n_tests++; if ({out_a0, psum0} !== {8'd20, 8'd13}) begin n_fail++; $display("FAIL stall_hold got %0h want 140d", {out_a0, psum0}); end
  endtask

  task automatic test_mode1();
    do_reset();
    load_w(8'h00); commit_w(2'd0);
    mac(8'd5, 8'd10);
    n_tests++; if (psum0 !== 8'd5) begin n_fail++; $display("FAIL m1_w0 got %0d want 5", psum0); end
    load_w(8'h01); commit_w(2'd0);
    mac(8'd5, 8'd10);
    n_tests++; if (psum0 !== 8'd15) begin n_fail++; $display("FAIL m1_w1 got %0d want 15", psum0); end
    // 4-bit weight 0x4 = +0.5 in Q0.3: 40 * 0.5 + 1
    load_w(8'hF4); commit_w(2'd2);
    mac(8'd40, 8'd1);
    n_tests++; if (psum0 !== 8'd21) begin n_fail++; $display("FAIL m4 got %0d want 21", psum0); end
    // 2-bit weight 0b11 = -0.5: (-7 * -1) >>> 1 = 3, plus 2
    load_w(8'h03); commit_w(2'd1);
    mac(8'hF9, 8'd2);
    n_tests++; if (psum0 !== 8'd5) begin n_fail++; $display("FAIL m2 got %0d want 5", psum0); end
  endtask

  task automatic test_overflow();
    logic [BW-1:0] want_pos, want_neg;
`ifdef SYSTOLIC_PE_SAT_EN
    want_pos = 8'h7F; want_neg = 8'h80;
`else
    want_pos = 8'hE2; want_neg = 8'h1D;
`endif
    do_reset();
    load_w(8'h7F); commit_w(2'd3);
    mac(8'd127, 8'd100);
    n_tests++; if (psum0 !== want_pos) begin n_fail++; $display("FAIL ovf_pos got %0h want %0h", psum0, want_pos); end
    mac(8'h80, 8'h9C);
    n_tests++; if (psum0 !== want_neg) begin n_fail++; $display("FAIL ovf_neg got %0h want %0h", psum0, want_neg); end
  endtask

  task automatic test_commit_race();
    do_reset();
    load_w(8'h40); commit_w(2'd3);
    load_w(8'h20);
    in_commit = 1; in_mode = 2'd3;
    mac(8'd16, 8'd0);
    in_commit = 0;
    n_tests++; if (psum0 !== 8'd8) begin n_fail++; $display("FAIL race_old got %0d want 8", psum0); end
    mac(8'd16, 8'd0);
    n_tests++; if (psum0 !== 8'd4) begin n_fail++; $display("FAIL race_new got %0d want 4", psum0); end
    // commit and load together: active takes old shadow (empty), shadow keeps new
    in_b = 8'h40; in_b_valid = 1; in_commit = 1; cycle(); in_b_valid = 0; in_commit = 0;
    n_tests++; if (wact0 !== 1'b0) begin n_fail++; $display("FAIL race_empty got %0b want 0", wact0); end
    commit_w(2'd3);
    mac(8'd20, 8'd3);
    n_tests++; if (psum0 !== 8'd13) begin n_fail++; $display("FAIL race_refill got %0d want 13", psum0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_w(8'h7F); commit_w(2'd3);
    in_b = 8'h10; in_b_valid = 1; in_commit = 1; res = 1; tick();
    res = 0; in_b_valid = 0; in_commit = 0; model_reset();
    n_tests++; if (wact0 !== 1'b0) begin n_fail++; $display("FAIL midrst_w_active got %0b want 0", wact0); end
    commit_w(2'd3);
    n_tests++; if (wact0 !== 1'b0) begin n_fail++; $display("FAIL midrst_shadow got %0b want 0", wact0); end
    mac(8'd50, 8'd7);
    n_tests++; if (psum0 !== 8'd7) begin n_fail++; $display("FAIL midrst_pass got %0d want 7", psum0); end
  endtask

  task automatic test_chain();
    do_reset();
    in_b = 8'h40; in_b_valid = 1; tick();
    in_b_valid = 0; in_commit = 1; in_mode = 2'd3; tick();
    in_commit = 0; tick();
    n_tests++; if ({bv2, b2} !== {1'b1, 8'h40}) begin n_fail++; $display("FAIL chain_b got %0h want 140", {bv2, b2}); end
    n_tests++; if ({wact1, wact2} !== 2'b10) begin n_fail++; $display("FAIL chain_pre got %0b want 10", {wact1, wact2}); end
    tick();
    n_tests++; if ({commit2, wact2} !== 2'b11) begin n_fail++; $display("FAIL chain_commit got %0b want 11", {commit2, wact2}); end
    in_valid = 1; in_a = 8'd20; in_psum = 8'd3; tick();
    in_valid = 0; in_a = 8'd1; in_psum = 8'd1; tick(); tick();
    n_tests++; if ({valid2, out_a2, psum2} !== {1'b1, 8'd20, 8'd33}) begin n_fail++; $display("FAIL chain_mac got %0h want 11421", {valid2, out_a2, psum2}); end
    tick();
    n_tests++; if ({valid2, out_a2, psum2} !== {1'b0, 8'd20, 8'd33}) begin n_fail++; $display("FAIL chain_hold got %0h want 01421", {valid2, out_a2, psum2}); end
    model_reset();
  endtask

  task automatic test_random();
    logic [BW-1:0] exp_a, exp_hold, exp_p;
    logic [MW-1:0] exp_b;
    logic          exp_v, exp_bv, exp_c;
    do_reset();
    exp_a = '0; exp_hold = '0;
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_a       = BW'($urandom_range(0, 255));
      in_psum    = BW'($urandom_range(0, 255));
      in_b       = MW'($urandom_range(0, 255));
      in_b_valid = ($urandom_range(0, 3) == 0);
      en_l_b     = ($urandom_range(0, 5) != 0);
      in_commit  = ($urandom_range(0, 6) == 0);
      in_mode    = 2'($urandom_range(0, 3));
      exp_v = in_valid; exp_b = in_b; exp_bv = in_b_valid; exp_c = in_commit;
      if (in_valid) begin
        exp_q.push_back(model_mac(in_a, in_psum));
        exp_a = in_a;
      end
      cycle();
      n_tests++; if (valid0 !== exp_v) begin n_fail++; $display("FAIL rnd_valid[%0d] got %0b want %0b", i, valid0, exp_v); end
      if (exp_v) begin
        exp_p = exp_q.pop_front();
        exp_hold = exp_p;
      end
      n_tests++; if (psum0 !== exp_hold) begin n_fail++; $display("FAIL rnd_psum[%0d] got %0h want %0h", i, psum0, exp_hold); end
      n_tests++; if (out_a0 !== exp_a) begin n_fail++; $display("FAIL rnd_out_a[%0d] got %0h want %0h", i, out_a0, exp_a); end
      n_tests++; if (wact0 !== m_avld) begin n_fail++; $display("FAIL rnd_w_active[%0d] got %0b want %0b", i, wact0, m_avld); end
      n_tests++; if ({b0, bv0, commit0} !== {exp_b, exp_bv, exp_c}) begin n_fail++; $display("FAIL rnd_chain[%0d] got %0h want %0h", i, {b0, bv0, commit0}, {exp_b, exp_bv, exp_c}); end
    end
    idle_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    res = 1;
    model_reset();
    test_reset();
    test_mode8();
    test_mode1();
    test_overflow();
    test_commit_race();
    test_reset_mid();
    test_chain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
